// File: rtl/crc_engine_if.sv
// Stream-side bundle for crc_engine: beat handshake plus frame result.
// master = beat source / result consumer, slave = the CRC engine.
interface crc_engine_if #(
    parameter int CRC_W  = 5,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_in;
    logic              sof;
    logic              eof;
    logic [CRC_W-1:0]  exp_crc;
    logic [CRC_W-1:0]  crc_out;
    logic              crc_valid;
    logic              crc_ok;
    logic [LEN_W-1:0]  frame_len;
    logic              err_orphan;

    modport master (
        output in_valid, data_in, sof, eof, exp_crc,
        input  in_ready, crc_out, crc_valid, crc_ok,
        input  frame_len, err_orphan
    );

    modport slave (
        input  in_valid, data_in, sof, eof, exp_crc,
        output in_ready, crc_out, crc_valid, crc_ok,
        output frame_len, err_orphan
    );
endinterface

// File: rtl/crc_engine.sv
// Frame-based CRC generator/checker, one DATA_W beat per clock (MSB first).
// Ports: ck, rst (async, active-high), bus (crc_engine_if.slave).
module crc_engine #(
    parameter int                CRC_W   = 5,
    parameter int                DATA_W  = 8,
    parameter logic [CRC_W-1:0]  POLY    = 'h05,
    parameter logic [CRC_W-1:0]  INIT    = '0,
    parameter logic [CRC_W-1:0]  XOR_OUT = '0,
    parameter int                LEN_W   = 16
) (
    input  logic          ck,
    input  logic          rst,
    crc_engine_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CRC_W-1:0] lfsr;
    logic [LEN_W-1:0] len;

    logic             acc;
    logic             fresh;
    logic [CRC_W-1:0] seed;
    logic [CRC_W-1:0] nxt;
    logic [CRC_W-1:0] fin;
    logic [LEN_W-1:0] nlen;

    // Whole beat folded into the register in one cycle, MSB first.
    function automatic logic [CRC_W-1:0] step(
        input logic [CRC_W-1:0]  s,
        input logic [DATA_W-1:0] d
    );
        logic [CRC_W-1:0] r;
        logic             fb;
        r = s;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = r[CRC_W-1] ^ d[i];
            r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return r;
    endfunction

    assign bus.in_ready = (state != DONE);
    assign acc          = bus.in_valid & bus.in_ready;

    // A sof beat restarts from INIT both in IDLE and as a mid-frame abort.
    assign fresh = (state == IDLE) | bus.sof;
    assign seed  = fresh ? INIT : lfsr;
    assign nxt   = step(seed, bus.data_in);
    assign fin   = nxt ^ XOR_OUT;

    always_comb begin
        nlen = len;
        if (fresh)
            nlen = LEN_W'(1);
        else if (len != '1)
            nlen = len + 1'b1;
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            lfsr           <= INIT;
            len            <= '0;
            bus.crc_out    <= '0;
            bus.crc_valid  <= 1'b0;
            bus.crc_ok     <= 1'b0;
            bus.frame_len  <= '0;
            bus.err_orphan <= 1'b0;
        end else begin
            bus.crc_valid <= 1'b0;
            unique case (state)
                IDLE, RUN: begin
                    if (acc) begin
                        if (state == IDLE && !bus.sof) begin
                            bus.err_orphan <= 1'b1;
                        end else begin
                            lfsr <= nxt;
                            len  <= nlen;
                            if (bus.eof) begin
                                bus.crc_out   <= fin;
                                bus.crc_ok    <= (fin == bus.exp_crc);
                                bus.frame_len <= nlen;
                                bus.crc_valid <= 1'b1;
                                state         <= DONE;
                            end else begin
                                state <= RUN;
                            end
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_engine.sv
// Self-checking bench for crc_engine: CRC-5 default, CRC-16/CCITT and
// LEN_W=2 instances share one beat stream; results checked against a model.
module tb_crc_engine;

    logic        ck;
    logic        rst;
    logic        v;
    logic [7:0]  dat;
    logic        s_f;
    logic        e_f;
    logic [15:0] x16;

    int checks;
    int failures;

    logic [7:0] msg[$];

    crc_engine_if #(.CRC_W(5))  i0 ();
    crc_engine_if #(.CRC_W(16)) i1 ();
    crc_engine_if #(.LEN_W(2))  i2 ();

    assign i0.in_valid = v;
    assign i0.data_in  = dat;
    assign i0.sof      = s_f;
    assign i0.eof      = e_f;
    assign i0.exp_crc  = x16[4:0];
    assign i1.in_valid = v;
    assign i1.data_in  = dat;
    assign i1.sof      = s_f;
    assign i1.eof      = e_f;
    assign i1.exp_crc  = x16;
    assign i2.in_valid = v;
    assign i2.data_in  = dat;
    assign i2.sof      = s_f;
    assign i2.eof      = e_f;
    assign i2.exp_crc  = x16[4:0];

    crc_engine u0 (
        .ck  (ck),
        .rst (rst),
        .bus (i0)
    );

    crc_engine #(
        .CRC_W (16),
        .POLY  (16'h1021),
        .INIT  (16'hFFFF)
    ) u1 (
        .ck  (ck),
        .rst (rst),
        .bus (i1)
    );

    crc_engine #(.LEN_W(2)) u2 (
        .ck  (ck),
        .rst (rst),
        .bus (i2)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Polynomial long division of (message * x^w) with INIT folded into
    // the leading w bits; generator is x^w + poly.
    function automatic logic [31:0] ref_crc(
        input int          w,
        input logic [31:0] poly,
        input logic [31:0] init,
        input logic [7:0]  m[$]
    );
        bit          b[$];
        int          n;
        logic [31:0] r;
        foreach (m[k])
            for (int i = 7; i >= 0; i--) b.push_back(m[k][i]);
        n = b.size();
        for (int i = 0; i < w; i++) b.push_back(1'b0);
        for (int i = 0; i < w; i++) b[i] = b[i] ^ init[w-1-i];
        for (int i = 0; i < n; i++) begin
            if (b[i]) begin
                b[i] = 1'b0;
                for (int j = 1; j <= w; j++)
                    b[i+j] = b[i+j] ^ poly[w-j];
            end
        end
        r = '0;
        for (int j = 0; j < w; j++) r = {r[30:0], b[n+j]};
        return r;
    endfunction

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic send(
        input logic [7:0]  d,
        input logic        s,
        input logic        e,
        input logic [15:0] x
    );
        bit got;
        dat = d;
        s_f = s;
        e_f = e;
        x16 = x;
        v   = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 8 && !got; n++) begin
            got = i0.in_ready;
            tick();
        end
        v = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL send_timeout got=0 exp=1");
        end
    endtask

    task automatic test_reset();
        checks++;
        if (i0.crc_out !== 5'h00 || i0.crc_valid !== 1'b0 ||
            i0.crc_ok !== 1'b0 || i0.frame_len !== 16'd0 ||
            i0.err_orphan !== 1'b0 || i0.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_init got=%h/%b/%b/%0d/%b/%b exp=00/0/0/0/0/1",
                     i0.crc_out, i0.crc_valid, i0.crc_ok,
                     i0.frame_len, i0.err_orphan, i0.in_ready);
        end
        rst = 1'b0;
        tick();
        send(8'h80, 1'b1, 1'b1, 16'h000E);
        tick();
        send(8'h80, 1'b1, 1'b0, 16'h0000);
        send(8'h40, 1'b0, 1'b0, 16'h0000);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (i0.crc_out !== 5'h00 || i0.crc_valid !== 1'b0 ||
            i0.frame_len !== 16'd0 || i0.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_async got=%h/%b/%0d/%b exp=00/0/0/1",
                     i0.crc_out, i0.crc_valid, i0.frame_len, i0.in_ready);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (i0.crc_valid !== 1'b0 || i0.in_ready !== 1'b1 ||
                i0.crc_ok !== 1'b0 || i0.err_orphan !== 1'b0) begin
                failures++;
                $display("FAIL reset_after got=%b/%b/%b/%b exp=0/1/0/0",
                         i0.crc_valid, i0.in_ready,
                         i0.crc_ok, i0.err_orphan);
            end
        end
    endtask

    task automatic test_single();
        send(8'h80, 1'b1, 1'b1, 16'h000E);
        checks++;
        if (i0.crc_valid !== 1'b1 || i0.crc_out !== 5'h0E ||
            i0.crc_ok !== 1'b1 || i0.frame_len !== 16'd1) begin
            failures++;
            $display("FAIL single_ok got=%b/%h/%b/%0d exp=1/0e/1/1",
                     i0.crc_valid, i0.crc_out, i0.crc_ok, i0.frame_len);
        end
        tick();
        send(8'h80, 1'b1, 1'b1, 16'h0000);
        checks++;
        if (i0.crc_valid !== 1'b1 || i0.crc_out !== 5'h0E ||
            i0.crc_ok !== 1'b0) begin
            failures++;
            $display("FAIL single_bad got=%b/%h/%b exp=1/0e/0",
                     i0.crc_valid, i0.crc_out, i0.crc_ok);
        end
        tick();
    endtask

    task automatic test_stall();
        int hi;
        send(8'h80, 1'b1, 1'b0, 16'h0000);
        tick();
        tick();
        tick();
        send(8'h00, 1'b0, 1'b1, 16'h000C);
        checks++;
        if (i0.crc_out !== 5'h0C || i0.frame_len !== 16'd2 ||
            i0.crc_ok !== 1'b1) begin
            failures++;
            $display("FAIL stall_res got=%h/%0d/%b exp=0c/2/1",
                     i0.crc_out, i0.frame_len, i0.crc_ok);
        end
        hi = 0;
        for (int k = 0; k < 4; k++) begin
            if (i0.crc_valid) hi++;
            tick();
        end
        checks++;
        if (hi !== 1) begin
            failures++;
            $display("FAIL stall_pulse got=%0d exp=1", hi);
        end
    endtask

    task automatic test_bubble();
        logic [7:0]  d;
        logic [31:0] r5;
        send(8'h80, 1'b1, 1'b1, 16'h000E);
        d   = 8'($urandom);
        msg = {d};
        r5  = ref_crc(5, 32'h05, 32'h0, msg);
        dat = d;
        s_f = 1'b1;
        e_f = 1'b1;
        v   = 1'b1;
        #1;
        checks++;
        if (i0.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bubble_ready got=%b exp=0", i0.in_ready);
        end
        send(d, 1'b1, 1'b1, 16'(r5));
        checks++;
        if (i0.crc_valid !== 1'b1 || i0.crc_out !== r5[4:0] ||
            i0.crc_ok !== 1'b1 || i0.frame_len !== 16'd1) begin
            failures++;
            $display("FAIL bubble_res got=%b/%h/%b/%0d exp=1/%h/1/1",
                     i0.crc_valid, i0.crc_out, i0.crc_ok,
                     i0.frame_len, r5[4:0]);
        end
        tick();
    endtask

    task automatic test_orphan();
        send(8'h55, 1'b0, 1'b0, 16'h0000);
        checks++;
        if (i0.err_orphan !== 1'b1 || i0.crc_valid !== 1'b0) begin
            failures++;
            $display("FAIL orphan_flag got=%b/%b exp=1/0",
                     i0.err_orphan, i0.crc_valid);
        end
        send(8'hAA, 1'b0, 1'b1, 16'h0000);
        checks++;
        if (i0.crc_valid !== 1'b0 || i0.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL orphan_eof got=%b/%b exp=0/1",
                     i0.crc_valid, i0.in_ready);
        end
        send(8'h12, 1'b1, 1'b0, 16'h0000);
        send(8'h34, 1'b0, 1'b0, 16'h0000);
        send(8'h80, 1'b1, 1'b1, 16'h000E);
        checks++;
        if (i0.crc_valid !== 1'b1 || i0.crc_out !== 5'h0E ||
            i0.crc_ok !== 1'b1 || i0.frame_len !== 16'd1) begin
            failures++;
            $display("FAIL abort_res got=%b/%h/%b/%0d exp=1/0e/1/1",
                     i0.crc_valid, i0.crc_out, i0.crc_ok, i0.frame_len);
        end
        tick();
        checks++;
        if (i0.err_orphan !== 1'b1) begin
            failures++;
            $display("FAIL orphan_sticky got=%b exp=1", i0.err_orphan);
        end
    endtask

    task automatic test_sweep();
        string s;
        s = "123456789";
        for (int k = 0; k < 9; k++)
            send(s[k], k == 0, k == 8, 16'h29B1);
        checks++;
        if (i1.crc_out !== 16'h29B1 || i1.frame_len !== 16'd9 ||
            i1.crc_ok !== 1'b1 || i1.crc_valid !== 1'b1) begin
            failures++;
            $display("FAIL crc16_check got=%h/%0d/%b/%b exp=29b1/9/1/1",
                     i1.crc_out, i1.frame_len, i1.crc_ok, i1.crc_valid);
        end
        tick();
        for (int k = 0; k < 5; k++)
            send(8'(k * 37), k == 0, k == 4, 16'h0000);
        checks++;
        if (i2.frame_len !== 2'd3 || i0.frame_len !== 16'd5) begin
            failures++;
            $display("FAIL len_sat got=%0d/%0d exp=3/5",
                     i2.frame_len, i0.frame_len);
        end
        tick();
    endtask

    task automatic test_random();
        int          n;
        logic [31:0] r5;
        logic [31:0] r16;
        logic [15:0] x;
        logic [15:0] ln2;
        for (int f = 0; f < 24; f++) begin
            n = int'($urandom_range(1, 6));
            msg.delete();
            for (int k = 0; k < n; k++) msg.push_back(8'($urandom));
            r5  = ref_crc(5, 32'h05, 32'h0, msg);
            r16 = ref_crc(16, 32'h1021, 32'hFFFF, msg);
            unique case (f % 3)
                0:       x = {5'($urandom), 6'($urandom), r5[4:0]};
                1:       x = r16[15:0];
                default: x = 16'($urandom);
            endcase
            for (int k = 0; k < n; k++) begin
                if (k > 0) repeat ($urandom_range(0, 2)) tick();
                send(msg[k], k == 0, k == n - 1, x);
            end
            ln2 = (n > 3) ? 16'd3 : 16'(n);
            checks++;
            if (i0.crc_valid !== 1'b1 || i0.crc_out !== r5[4:0] ||
                i0.crc_ok !== (r5[4:0] == x[4:0]) ||
                i0.frame_len !== 16'(n)) begin
                failures++;
                $display("FAIL rand_crc5 f=%0d got=%b/%h/%b/%0d exp=1/%h/%b/%0d",
                         f, i0.crc_valid, i0.crc_out, i0.crc_ok,
                         i0.frame_len, r5[4:0], r5[4:0] == x[4:0], n);
            end
            checks++;
            if (i1.crc_out !== r16[15:0] ||
                i1.crc_ok !== (r16[15:0] == x) ||
                i2.crc_out !== r5[4:0] ||
                16'(i2.frame_len) !== ln2) begin
                failures++;
                $display("FAIL rand_wide f=%0d got=%h/%b/%h/%0d exp=%h/%b/%h/%0d",
                         f, i1.crc_out, i1.crc_ok, i2.crc_out,
                         i2.frame_len, r16[15:0], r16[15:0] == x,
                         r5[4:0], ln2);
            end
            if ($urandom_range(0, 1) == 1) tick();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        v        = 1'b0;
        dat      = 8'h00;
        s_f      = 1'b0;
        e_f      = 1'b0;
        x16      = 16'h0000;
        tick();
        tick();
        test_reset();
        test_single();
        test_stall();
        test_bubble();
        test_orphan();
        test_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
